// File: rtl/shifter_core_pkg.sv
// ----------------------------------------------------------------------------
// shifter_pkg
// Shared types and constants for the RV32 execute-stage barrel shifter.
//   XLEN         : default datapath width
//   shift_type_e : shift operation encoding as delivered by the decoder
// ----------------------------------------------------------------------------
package shifter_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

endpackage

// File: rtl/shifter_core_if.sv
// ----------------------------------------------------------------------------
// shifter_core_if
// Operand/result bundle between the decoder/execute stage and the shifter.
//   in_valid  : operands valid this cycle
//   type_     : shift type (shift_type_e encoding)
//   in        : operand to be shifted
//   shift     : unsigned shift amount, 0..XLEN-1
//   out       : registered result
//   out_valid : out holds a valid result
// master = issuing side, slave = shifter.
// ----------------------------------------------------------------------------
interface shifter_core_if #(
    parameter int unsigned XLEN = shifter_pkg::XLEN
) ();

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic               in_valid;
    logic [1:0]         type_;
    logic [XLEN-1:0]    in;
    logic [SHAMT_W-1:0] shift;
    logic [XLEN-1:0]    out;
    logic               out_valid;

    modport master (
        output in_valid, type_, in, shift,
        input  out, out_valid
    );

    modport slave (
        input  in_valid, type_, in, shift,
        output out, out_valid
    );

endinterface

// File: rtl/shifter_core_stage.sv
// ----------------------------------------------------------------------------
// shifter_stage
// One stage of the right-shifting barrel network.
//   data_i : stage input data
//   fill_i : source of the bits entering at the MSB end; its low DIST bits
//            are used (zeros, replicated sign, or data_i itself to rotate)
//   en_i   : shift by DIST when set, pass through otherwise
//   data_o : stage output
// ----------------------------------------------------------------------------
module shifter_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned DIST = 1
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [XLEN-1:0] fill_i,
    input  logic            en_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            data_o = {fill_i[DIST-1:0], data_i[XLEN-1:DIST]};
        end
    end

endmodule

// File: rtl/shifter_core.sv
// ----------------------------------------------------------------------------
// shifter_core
// Barrel shifter (SLL/SRL/SRA/ROR) with one registered output stage.
//   clk : system clock
//   rst : asynchronous active-high reset, clears out/out_valid immediately
//   bus : shifter_core_if.slave (in_valid, type_, in, shift -> out, out_valid)
// Latency is exactly one cycle; a new operation may be issued every cycle.
// out is reloaded every cycle, so consumers must qualify it with out_valid.
// ----------------------------------------------------------------------------
module shifter_core
    import shifter_pkg::*;
#(
    parameter int unsigned XLEN    = shifter_pkg::XLEN,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic          clk,
    input  logic          rst,
    shifter_core_if.slave bus
);

    shift_type_e sh_type;
    assign sh_type = shift_type_e'(bus.type_);

    logic [XLEN-1:0]              in_rev;
    logic [XLEN-1:0]              res_rev;
    logic [XLEN-1:0]              res;
    logic [SHAMT_W:0][XLEN-1:0]   stage_data;
    logic [SHAMT_W-1:0][XLEN-1:0] stage_fill;
    logic [XLEN-1:0]              sign_fill;

    // SLL reuses the right-shift network: reverse, shift right with zero fill,
    // reverse back.
    for (genvar i = 0; i < XLEN; i++) begin : g_rev
        assign in_rev[i]  = bus.in[XLEN-1-i];
        assign res_rev[i] = stage_data[SHAMT_W][XLEN-1-i];
    end

    assign sign_fill     = {XLEN{bus.in[XLEN-1]}};
    assign stage_data[0] = (sh_type == SHIFT_SLL) ? in_rev : bus.in;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        // ROR feeds the stage its own input so the bits shifted out re-enter
        // at the top; SRA feeds the original sign bit, which never changes.
        assign stage_fill[k] = (sh_type == SHIFT_ROR) ? stage_data[k] :
                               (sh_type == SHIFT_SRA) ? sign_fill     : '0;

        shifter_stage #(
            .XLEN (XLEN),
            .DIST (2 ** k)
        ) u_stage (
            .data_i (stage_data[k]),
            .fill_i (stage_fill[k]),
            .en_i   (bus.shift[k]),
            .data_o (stage_data[k+1])
        );
    end

    assign res = (sh_type == SHIFT_SLL) ? res_rev : stage_data[SHAMT_W];

    logic [XLEN-1:0] out_d, out_q;
    logic            out_valid_d, out_valid_q;

    assign out_d       = res;
    assign out_valid_d = bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_shifter_core.sv
// ----------------------------------------------------------------------------
// tb_shifter_core
// Scoreboard bench: the driver pushes one expected entry per issued cycle,
// the monitor pops on each capturing edge and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_shifter_core;

    localparam int unsigned XLEN = 32;

    typedef struct {
        bit          v;
        logic [31:0] d;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t q[$];

    shifter_core_if #(.XLEN(XLEN)) bus ();

    shifter_core #(.XLEN(XLEN)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the operation definitions.
    function automatic logic [31:0] model(input int t, input logic [31:0] a, input int s);
        logic [63:0] dbl;
        case (t)
            0:       return a << s;
            1:       return a >> s;
            2:       return 32'($signed(a) >>> s);
            default: begin
                dbl = {a, a} >> s;
                return dbl[31:0];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int t, input logic [31:0] a, input int s);
        bus.in_valid = v;
        bus.type_    = 2'(t);
        bus.in       = a;
        bus.shift    = 5'(s);
    endtask

    task automatic issue_exp(input string name, input bit v, input int t, input logic [31:0] a,
                             input int s, input logic [31:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        drive(v, t, a, s);
        x.v = v;
        x.d = e;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic issue(input string name, input bit v, input int t, input logic [31:0] a,
                         input int s);
        issue_exp(name, v, t, a, s, model(t, a, s));
    endtask

    // Monitor: the entry pushed before an edge is the one that edge captures.
    initial begin
        exp_t cur;
        forever begin
            @(posedge clk);
            if (!rst && q.size() > 0) begin
                cur = q.pop_front();
                @(negedge clk);
                if (!rst) begin
                    check({cur.name, "_valid"}, 32'(bus.out_valid), 32'(cur.v));
                    if (cur.v) check(cur.name, bus.out, cur.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int s;
        logic [31:0] a;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b0, 0, 32'h0, 0);
        #2 rst = 1'b1;
        #2;
        check("reset_out", bus.out, 32'h0);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        issue_exp("sll_31",  1'b1, 0, 32'h00000001, 31, 32'h80000000);
        issue_exp("srl_1",   1'b1, 1, 32'h00000002, 1,  32'h00000001);
        issue_exp("srl_31",  1'b1, 1, 32'h80000000, 31, 32'h00000001);
        issue_exp("sra_31",  1'b1, 2, 32'h80000000, 31, 32'hFFFFFFFF);
        issue_exp("sra_4",   1'b1, 2, 32'h7FFFFFFF, 4,  32'h07FFFFFF);
        issue_exp("ror_1",   1'b1, 3, 32'h00000001, 1,  32'h80000000);
        issue_exp("sll_0",   1'b1, 0, 32'hDEADBEEF, 0,  32'hDEADBEEF);
        issue_exp("srl_0",   1'b1, 1, 32'hDEADBEEF, 0,  32'hDEADBEEF);
        issue_exp("sra_0",   1'b1, 2, 32'hDEADBEEF, 0,  32'hDEADBEEF);
        issue_exp("ror_0",   1'b1, 3, 32'hDEADBEEF, 0,  32'hDEADBEEF);
        issue_exp("bubble",  1'b0, 3, 32'h12345678, 4,  32'h0);
        issue_exp("ror_31",  1'b1, 3, 32'h80000001, 31, 32'h00000003);

        // Back-to-back randomized operations with occasional bubbles.
        for (int i = 0; i < 300; i++) begin
            t = int'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       s = 0;
                1:       s = 31;
                default: s = int'($urandom_range(0, 31));
            endcase
            issue("rand", ($urandom_range(0, 7) != 0), t, a, s);
        end

        // Reset mid-operation: the in-flight result must vanish at once.
        issue("pre_rst", 1'b1, 2, 32'h80F0F0F0, 3);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out", bus.out, 32'h0);
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        q.delete();
        begin
            exp_t x;
            drive(1'b1, 0, 32'h0000000F, 4);
            x.v = 1'b1;
            x.d = 32'h000000F0;
            x.name = "post_rst";
            q.push_back(x);
        end
        @(negedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            issue("rand_post", 1'b1, int'($urandom_range(0, 3)), $urandom,
                  int'($urandom_range(0, 31)));
        end
        issue("drain0", 1'b0, 0, 32'h0, 0);
        issue("drain1", 1'b0, 0, 32'h0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_empty", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
